irq_pend_ctrl: RTL and testbench

- Interrupt pending/handshake stage that wraps the existing 8:3 priority encoder.
- Upstream role:
  - Edge-detects 8 raw request lines and latches them as sticky pending bits.
  - Applies a mask and drives the masked vector into the encoder inputs i0..i7.
- Downstream role:
  - Consumes the encoder's o2..o0 and valid outputs.
  - Presents one interrupt ID at a time to the CPU via an irq/ack handshake.
  - Clears the serviced pending bit on ack.

---
 rtl/irq_pkg.sv | 10 +
 rtl/irq_edge_det.sv | 56 +++++
 rtl/prienc83.sv | 32 +++
 rtl/irq_pend_ctrl.sv | 87 ++++++++
 tb/tb_irq_pend_ctrl.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared constants and FSM state type for the interrupt pending controller
package irq_pkg;
    localparam int N_IRQ = 8;
    localparam int ID_W  = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } irq_state_e;
endpackage

// File: rtl/irq_edge_det.sv
// rtl/irq_edge_det.sv - rising-edge detect of raw request lines; IRQ_SYNC_EN adds a 2-flop synchronizer
module irq_edge_det
    import irq_pkg::*;
#(
    parameter int WIDTH = N_IRQ
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] irq_in,
    output logic [WIDTH-1:0] edge_o
);
    logic [WIDTH-1:0] irq_s;
    logic [WIDTH-1:0] irq_dly_q;
    logic [WIDTH-1:0] irq_dly_d;

`ifdef IRQ_SYNC_EN
    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] sync1_d;
    logic [WIDTH-1:0] sync2_d;

    always_comb begin
        sync1_d = irq_in;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign irq_s = sync2_q;
`else
    assign irq_s = irq_in;
`endif

    // Previous sample resets to 0 so a line already high at release counts as one edge.
    always_comb begin
        irq_dly_d = irq_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_dly_q <= '0;
        end else begin
            irq_dly_q <= irq_dly_d;
        end
    end

    assign edge_o = irq_s & ~irq_dly_q;
endmodule

// File: rtl/prienc83.sv
// rtl/prienc83.sv - combinational 8:3 priority encoder, highest index wins
module prienc83 (
    input  logic i0,
    input  logic i1,
    input  logic i2,
    input  logic i3,
    input  logic i4,
    input  logic i5,
    input  logic i6,
    input  logic i7,
    output logic o2,
    output logic o1,
    output logic o0,
    output logic valid
);
    logic [7:0] in_vec;
    logic [2:0] code;

    assign in_vec = {i7, i6, i5, i4, i3, i2, i1, i0};

    always_comb begin
        code = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (in_vec[k]) begin
                code = 3'(k);
            end
        end
    end

    assign valid      = |in_vec;
    assign {o2, o1, o0} = code;
endmodule

// File: rtl/irq_pend_ctrl.sv
// rtl/irq_pend_ctrl.sv - sticky pending/overrun tracking and irq/ack handshake around an external 8:3 encoder (option: IRQ_SYNC_EN)
module irq_pend_ctrl
    import irq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic [N_IRQ-1:0] mask_in,
    output logic [N_IRQ-1:0] pend_vec_o,
    input  logic [ID_W-1:0]  enc_code_i,
    input  logic             enc_valid_i,
    output logic             irq_o,
    output logic [ID_W-1:0]  irq_id_o,
    input  logic             irq_ack_i,
    output logic [N_IRQ-1:0] ovr_o,
    input  logic             ovr_clr_i
);
    logic [N_IRQ-1:0] edge_vec;
    logic [N_IRQ-1:0] clr_vec;
    logic [N_IRQ-1:0] ovr_set;

    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] ovr_q, ovr_d;
    logic [ID_W-1:0]  irq_id_q, irq_id_d;
    irq_state_e       state_q, state_d;

    irq_edge_det #(
        .WIDTH (N_IRQ)
    ) u_edge_det (
        .clk    (clk),
        .rst_n  (rst_n),
        .irq_in (irq_in),
        .edge_o (edge_vec)
    );

    always_comb begin
        clr_vec = '0;
        if (state_q == ACTIVE && irq_ack_i) begin
            clr_vec[irq_id_q] = 1'b1;
        end
    end

    // A new edge re-pends a line even while its ack clears it; that is not an overrun.
    always_comb begin
        ovr_set   = edge_vec & pending_q & ~clr_vec;
        pending_d = (pending_q & ~clr_vec) | edge_vec;
        ovr_d     = (ovr_clr_i ? '0 : ovr_q) | ovr_set;
    end

    always_comb begin
        state_d  = state_q;
        irq_id_d = irq_id_q;
        case (state_q)
            IDLE: begin
                if (enc_valid_i) begin
                    irq_id_d = enc_code_i;
                    state_d  = ACTIVE;
                end
            end
            ACTIVE: begin
                if (irq_ack_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            ovr_q     <= '0;
            irq_id_q  <= '0;
            state_q   <= IDLE;
        end else begin
            pending_q <= pending_d;
            ovr_q     <= ovr_d;
            irq_id_q  <= irq_id_d;
            state_q   <= state_d;
        end
    end

    assign pend_vec_o = pending_q & mask_in;
    assign irq_o      = (state_q == ACTIVE);
    assign irq_id_o   = irq_id_q;
    assign ovr_o      = ovr_q;
endmodule

// File: tb/tb_irq_pend_ctrl.sv
// tb/tb_irq_pend_ctrl.sv - directed self-checking bench for irq_pend_ctrl with prienc83 in the loop
module tb_irq_pend_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] irq_in;
    logic [7:0] mask_in;
    logic [7:0] pend_vec_o;
    logic [2:0] enc_code;
    logic       enc_valid;
    logic       irq_o;
    logic [2:0] irq_id_o;
    logic       irq_ack_i;
    logic [7:0] ovr_o;
    logic       ovr_clr_i;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    always #5 clk = ~clk;

    irq_pend_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .irq_in      (irq_in),
        .mask_in     (mask_in),
        .pend_vec_o  (pend_vec_o),
        .enc_code_i  (enc_code),
        .enc_valid_i (enc_valid),
        .irq_o       (irq_o),
        .irq_id_o    (irq_id_o),
        .irq_ack_i   (irq_ack_i),
        .ovr_o       (ovr_o),
        .ovr_clr_i   (ovr_clr_i)
    );

    prienc83 u_enc (
        .i0    (pend_vec_o[0]),
        .i1    (pend_vec_o[1]),
        .i2    (pend_vec_o[2]),
        .i3    (pend_vec_o[3]),
        .i4    (pend_vec_o[4]),
        .i5    (pend_vec_o[5]),
        .i6    (pend_vec_o[6]),
        .i7    (pend_vec_o[7]),
        .o2    (enc_code[2]),
        .o1    (enc_code[1]),
        .o0    (enc_code[0]),
        .valid (enc_valid)
    );

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: per-line pending/overrun bits plus one presented ID.
    bit m_prev[8];
    bit m_pend[8];
    bit m_ovr[8];
    bit m_active = 1'b0;
    int m_id     = 0;

    initial begin
        for (int k = 0; k < 8; k++) begin
            m_prev[k] = 1'b0;
            m_pend[k] = 1'b0;
            m_ovr[k]  = 1'b0;
        end
    end

    always @(posedge clk or negedge rst_n) begin : model
        int  top;
        bit  rise;
        bit  served;
        bit  np[8];
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) begin
                m_prev[k] = 1'b0;
                m_pend[k] = 1'b0;
                m_ovr[k]  = 1'b0;
            end
            m_active = 1'b0;
            m_id     = 0;
        end else begin
            top = -1;
            for (int k = 0; k < 8; k++) begin
                if (m_pend[k] && mask_in[k]) top = k;
            end
            for (int k = 0; k < 8; k++) begin
                rise   = irq_in[k] && !m_prev[k];
                served = m_active && irq_ack_i && (m_id == k);
                np[k]  = rise || (m_pend[k] && !served);
                if (rise && m_pend[k] && !served) m_ovr[k] = 1'b1;
                else if (ovr_clr_i)               m_ovr[k] = 1'b0;
                m_prev[k] = irq_in[k];
            end
            for (int k = 0; k < 8; k++) m_pend[k] = np[k];
            if (!m_active) begin
                if (top >= 0) begin
                    m_active = 1'b1;
                    m_id     = top;
                end
            end else if (irq_ack_i) begin
                m_active = 1'b0;
            end
        end
    end

    function automatic logic [7:0] pack(input bit v[8]);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = v[k];
        return r;
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_pend_vec", pend_vec_o, pack(m_pend) & mask_in);
            chk("cyc_irq_o", {7'd0, irq_o}, {7'd0, m_active});
            if (m_active) chk("cyc_irq_id", {5'd0, irq_id_o}, 8'(m_id));
            chk("cyc_ovr", ovr_o, pack(m_ovr));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ack();
        irq_ack_i = 1'b1;
        step();
        irq_ack_i = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        irq_in    = 8'hFF;
        mask_in   = 8'hFF;
        irq_ack_i = 1'b0;
        ovr_clr_i = 1'b0;
        step();
        step();
        cmp_en = 1'b1;
        chk("rst_irq_o", {7'd0, irq_o}, 8'h00);
        chk("rst_pend", pend_vec_o, 8'h00);
        chk("rst_ovr", ovr_o, 8'h00);

        rst_n = 1'b1;
        step();
        chk("rel_pend_clk1", pend_vec_o, 8'hFF);
        chk("rel_irq_clk1", {7'd0, irq_o}, 8'h00);
        step();
        chk("rel_irq_clk2", {7'd0, irq_o}, 8'h01);
        chk("rel_id_clk2", {5'd0, irq_id_o}, 8'd7);
        for (int id = 7; id >= 0; id--) begin
            ack();
            chk("drain_gap", {7'd0, irq_o}, 8'h00);
            step();
            if (id > 0) chk("drain_id", {5'd0, irq_id_o}, 8'(id - 1));
            else        chk("drain_done", {7'd0, irq_o}, 8'h00);
        end

        irq_in = 8'h00;
        step();
        irq_in = 8'h08;
        step();
        chk("single_clk1", {7'd0, irq_o}, 8'h00);
        step();
        chk("single_irq", {7'd0, irq_o}, 8'h01);
        chk("single_id", {5'd0, irq_id_o}, 8'd3);
        ack();
        chk("single_ack_irq", {7'd0, irq_o}, 8'h00);
        chk("single_ack_pend", pend_vec_o, 8'h00);

        irq_in = 8'h62;
        step();
        step();
        chk("prio_id6", {5'd0, irq_id_o}, 8'd6);
        ack();
        chk("prio_gap1", {7'd0, irq_o}, 8'h00);
        step();
        chk("prio_id5", {5'd0, irq_id_o}, 8'd5);
        ack();
        chk("prio_gap2", {7'd0, irq_o}, 8'h00);
        step();
        chk("prio_id1", {5'd0, irq_id_o}, 8'd1);
        ack();
        step();
        chk("prio_empty", pend_vec_o, 8'h00);

        irq_in  = 8'h00;
        mask_in = 8'h00;
        step();
        irq_in = 8'h04;
        step();
        step();
        chk("mask_irq", {7'd0, irq_o}, 8'h00);
        chk("mask_pend", pend_vec_o, 8'h00);
        mask_in = 8'h04;
        step();
        chk("unmask_irq", {7'd0, irq_o}, 8'h01);
        chk("unmask_id", {5'd0, irq_id_o}, 8'd2);
        ack();
        mask_in = 8'hFF;

        irq_in = 8'h10;
        step();
        irq_in = 8'h00;
        step();
        irq_in = 8'h10;
        step();
        chk("ovr_set", ovr_o, 8'h10);
        ovr_clr_i = 1'b1;
        step();
        ovr_clr_i = 1'b0;
        chk("ovr_clr", ovr_o, 8'h00);
        irq_in = 8'h00;
        step();
        irq_in    = 8'h10;
        irq_ack_i = 1'b1;
        step();
        irq_ack_i = 1'b0;
        chk("coll_pend", pend_vec_o, 8'h10);
        chk("coll_ovr", ovr_o, 8'h00);
        chk("coll_irq", {7'd0, irq_o}, 8'h00);
        step();
        chk("coll_reirq_id", {5'd0, irq_id_o}, 8'd4);
        irq_in = 8'h00;
        step();
        irq_in = 8'h10;
        step();
        chk("pre_rst_ovr", ovr_o, 8'h10);
        chk("pre_rst_irq", {7'd0, irq_o}, 8'h01);

        rst_n = 1'b0;
        #1;
        chk("midrst_irq", {7'd0, irq_o}, 8'h00);
        chk("midrst_pend", pend_vec_o, 8'h00);
        chk("midrst_ovr", ovr_o, 8'h00);
        irq_in = 8'h00;
        step();
        rst_n = 1'b1;
        ack();
        chk("post_rst_irq", {7'd0, irq_o}, 8'h00);
        chk("post_rst_pend", pend_vec_o, 8'h00);
        step();
        cmp_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
